// File: rtl/circuit1_pipe_if.sv
// circuit1_pipe_if: operand/result handshake bundle for circuit1_pipe
interface circuit1_pipe_if #(parameter int DATAWIDTH = 16);
  logic                 in_valid, in_ready, out_valid, out_ready, gt;
  logic [DATAWIDTH-1:0] a, b, c, z, x;
  modport master(output in_valid, a, b, c, out_ready, input in_ready, out_valid, z, x, gt);
  modport slave(input in_valid, a, b, c, out_ready, output in_ready, out_valid, z, x, gt);
endinterface

// File: rtl/circuit1_pipe.sv
// circuit1_pipe: two-stage pipeline computing z = max(a+b, a+c), x = a*c - (a+b), gt = (a+b > a+c)
module circuit1_pipe #(
  parameter int DATAWIDTH = 16,
  parameter bit SIGNED    = 1'b0
) (
  input logic Clk,
  input logic Rst,
  circuit1_pipe_if.slave io
);
  logic                 advance;
  logic [DATAWIDTH-1:0] sum_ab, sum_ac, prod;
  logic                 v1_d, v1_q, g1_d, g1_q, ov_d, ov_q, gt_d, gt_q;
  logic [DATAWIDTH-1:0] d1_d, d1_q, e1_d, e1_q, f1_d, f1_q, z_d, z_q, x_d, x_q;
  // Both stages shift together; the whole pipe stalls only when a result is waiting.
  always_comb begin
    advance = !ov_q || io.out_ready;
    sum_ab  = io.a + io.b;
    sum_ac  = io.a + io.c;
    prod    = io.a * io.c;
    v1_d    = advance ? io.in_valid : v1_q;
    d1_d    = advance ? sum_ab : d1_q;
    e1_d    = advance ? sum_ac : e1_q;
    f1_d    = advance ? prod : f1_q;
    g1_d    = advance ? (SIGNED ? ($signed(sum_ab) > $signed(sum_ac)) : (sum_ab > sum_ac)) : g1_q;
    ov_d    = advance ? v1_q : ov_q;
    z_d     = advance ? (g1_q ? d1_q : e1_q) : z_q;
    x_d     = advance ? f1_q - d1_q : x_q;
    gt_d    = advance ? g1_q : gt_q;
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v1_q <= 1'b0;
      g1_q <= 1'b0;
      d1_q <= '0;
      e1_q <= '0;
      f1_q <= '0;
      ov_q <= 1'b0;
      z_q  <= '0;
      x_q  <= '0;
      gt_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      g1_q <= g1_d;
      d1_q <= d1_d;
      e1_q <= e1_d;
      f1_q <= f1_d;
      ov_q <= ov_d;
      z_q  <= z_d;
      x_q  <= x_d;
      gt_q <= gt_d;
    end
  end
  assign io.in_ready  = advance;
  assign io.out_valid = ov_q;
  assign io.z         = z_q;
  assign io.x         = x_q;
  assign io.gt        = gt_q;
endmodule

// File: tb/tb_circuit1_pipe.sv
// tb_circuit1_pipe: drives unsigned and signed instances in lockstep, scoreboarding hand-computed results
module tb_circuit1_pipe;
  typedef struct {
    logic [15:0] a, b, c;
    logic [15:0] z0, x0;
    logic        g0;
    logic [15:0] z1, x1;
    logic        g1;
  } vec_t;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   checks = 0, errors = 0, n_out = 0, cyc = 0;
  vec_t tbl [10];
  vec_t q[$];
  vec_t cur, e;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_z, prev_x;
  logic        prev_gt;
  circuit1_pipe_if #(.DATAWIDTH(16)) io0 ();
  circuit1_pipe_if #(.DATAWIDTH(16)) io1 ();
  assign io1.in_valid  = io0.in_valid;
  assign io1.a         = io0.a;
  assign io1.b         = io0.b;
  assign io1.c         = io0.c;
  assign io1.out_ready = io0.out_ready;
  circuit1_pipe #(.DATAWIDTH(16), .SIGNED(1'b0)) dut0 (.Clk(Clk), .Rst(Rst), .io(io0.slave));
  circuit1_pipe #(.DATAWIDTH(16), .SIGNED(1'b1)) dut1 (.Clk(Clk), .Rst(Rst), .io(io1.slave));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endfunction
  always @(negedge Clk) begin
    if (Rst) begin
      if (prev_stall && io0.out_valid) begin
        chk("stall_z", io0.z, prev_z);
        chk("stall_x", io0.x, prev_x);
        chk("stall_gt", io0.gt, prev_gt);
      end
      prev_stall = io0.out_valid && !io0.out_ready;
      prev_z     = io0.z;
      prev_x     = io0.x;
      prev_gt    = io0.gt;
      if (io0.out_valid && io0.out_ready) begin
        if (q.size() == 0) chk("unexpected_out", io0.out_valid, 1'b0);
        else begin
          e = q.pop_front();
          n_out++;
          chk("z_u", io0.z, e.z0);
          chk("x_u", io0.x, e.x0);
          chk("gt_u", io0.gt, e.g0);
          chk("ov_s", io1.out_valid, 1'b1);
          chk("z_s", io1.z, e.z1);
          chk("x_s", io1.x, e.x1);
          chk("gt_s", io1.gt, e.g1);
        end
      end
      if (io0.in_valid && io0.in_ready) q.push_back(cur);
    end else prev_stall = 1'b0;
  end
  task automatic send(input vec_t v);
    bit done = 1'b0;
    io0.a = v.a; io0.b = v.b; io0.c = v.c; io0.in_valid = 1'b1; cur = v;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge Clk);
      done = io0.in_ready;
      @(posedge Clk);
      #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stayed %b expected 1", io0.in_ready);
    end
    io0.in_valid = 1'b0;
  endtask
  task automatic lat(input vec_t v, input string nm);
    send(v);
    chk({nm, "_lat1"}, io0.out_valid, 1'b0);
    @(posedge Clk); #1;
    chk({nm, "_lat2"}, io0.out_valid, 1'b1);
    @(posedge Clk); #1;
  endtask
  initial begin
    int n0, c0;
    tbl[0] = '{16'd3, 16'd4, 16'd5, 16'd8, 16'd8, 1'b0, 16'd8, 16'd8, 1'b0};
    tbl[1] = '{16'd10, 16'd20, 16'd2, 16'h001E, 16'hFFF6, 1'b1, 16'h001E, 16'hFFF6, 1'b1};
    tbl[2] = '{16'hFFFF, 16'd1, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16'h0000, 16'h0001, 1'b1};
    tbl[3] = '{16'd0, 16'hFFFF, 16'd1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1'b0};
    tbl[4] = '{16'h8000, 16'd0, 16'd0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h8000, 1'b0};
    tbl[5] = '{16'h7FFF, 16'd1, 16'd2, 16'h8001, 16'h7FFE, 1'b0, 16'h8001, 16'h7FFE, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1};
    tbl[7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0};
    tbl[8] = '{16'd100, 16'd50, 16'd3, 16'd150, 16'h0096, 1'b1, 16'd150, 16'h0096, 1'b1};
    tbl[9] = '{16'h1234, 16'h0001, 16'h0010, 16'h1244, 16'h110B, 1'b0, 16'h1244, 16'h110B, 1'b0};
    io0.in_valid = 1'b0; io0.out_ready = 1'b1; io0.a = '0; io0.b = '0; io0.c = '0;
    #3;
    chk("rst_ov", io0.out_valid, 1'b0);
    chk("rst_z", io0.z, 16'd0);
    chk("rst_x", io0.x, 16'd0);
    chk("rst_gt", io0.gt, 1'b0);
    chk("rst_in_ready", io0.in_ready, 1'b1);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    lat(tbl[0], "first");
    n0 = n_out; c0 = cyc;
    for (int i = 0; i < 10; i++) send(tbl[i]);
    chk("stream_cycles", cyc - c0, 10);
    @(posedge Clk); @(negedge Clk); #1;
    chk("stream_count", n_out - n0, 10);
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      io0.a = 16'($urandom); io0.b = 16'($urandom); io0.c = 16'($urandom);
      @(posedge Clk); #1;
    end
    chk("idle_no_output", n_out - n0, 0);
    n0 = n_out;
    fork
      begin send(tbl[1]); send(tbl[2]); send(tbl[3]); end
      begin
        io0.out_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk("full_in_ready", io0.in_ready, 1'b0);
        chk("full_out_valid", io0.out_valid, 1'b1);
        repeat (3) @(posedge Clk);
        #1 io0.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge Clk);
    #1 chk("bp_count", n_out - n0, 3);
    chk("bp_queue_empty", q.size(), 0);
    io0.out_ready = 1'b0;
    send(tbl[4]); send(tbl[5]);
    #2 Rst = 1'b0;
    #1 chk("midrst_ov_u", io0.out_valid, 1'b0);
    chk("midrst_ov_s", io1.out_valid, 1'b0);
    chk("midrst_z", io0.z, 16'd0);
    q.delete();
    @(posedge Clk); #1 Rst = 1'b1;
    io0.out_ready = 1'b1;
    n0 = n_out;
    repeat (3) @(posedge Clk);
    #1 chk("post_rst_no_stale", n_out - n0, 0);
    lat(tbl[6], "post_rst");
    repeat (2) @(posedge Clk);
    #1 chk("final_count", n_out - n0, 1);
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/circuit1_pipe.md
CIRCUIT1_PIPE -- requirements
Module: circuit1_pipe

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16: width of every data port and every internal datapath word.
REQ-002 The block SHALL have parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-low reset (Rst=0 resets).
REQ-005 in_valid  input  1  operand set a/b/c is valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a, b, c  input  DATAWIDTH each  operands.
REQ-008 out_valid  output  1  z/x hold a valid result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 z, x  output  DATAWIDTH each  results.
REQ-011 gt  output  1  compare flag belonging to the presented result.

Function
REQ-012 Arithmetic: d=a+b, e=a+c, f=a*c.
- Each result is truncated to the low DATAWIDTH bits (modulo 2^DATAWIDTH).
- Low product bits are identical for both SIGNED settings.
REQ-013 Compare: g = (d > e).
- SIGNED=0: unsigned compare.
- SIGNED=1: two's-complement compare.
REQ-014 Results: z = g ? d : e (larger of d, e); x = f - d modulo 2^DATAWIDTH; gt = g.
REQ-015 Pipeline: two stages.
- Stage 1 registers d, e, f, g and valid bit v1.
- Stage 2 registers z, x, gt and out_valid.
REQ-016 Latency: exactly 2 Clk edges from acceptance to out_valid when not stalled.
REQ-017 advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-018 Transfers: input accepted iff in_valid && in_ready; output consumed iff out_valid && out_ready.
REQ-019 On advance:
- Stage 1 loads in_valid and new operands.
- Stage 2 loads v1 and stage-1 results.
- A bubble (v1=0) yields out_valid=0.
REQ-020 On !advance: both stages hold; z, x, gt stay bit-stable while out_valid=1 and out_ready=0.
REQ-021 Full throughput: one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-022 Capacity: up to 2 results in flight; none are dropped or duplicated under any backpressure pattern.
REQ-023 Input side: a/b/c values with in_valid=0 SHALL NOT produce an output.
REQ-024 Input side: a/b/c values are ignored when in_ready=0.
REQ-025 Simultaneous consume and accept in one cycle SHALL be legal; the pipeline shifts by one.
REQ-026 Boundary values (all-ones, zero, most-negative) SHALL wrap per REQ-012 with no error signalling.

Reset
REQ-027 Rst=0 SHALL immediately, independent of Clk, clear: v1=0, out_valid=0, z=0, x=0, gt=0.
REQ-028 While Rst=0, in_ready SHALL be 1 (pipeline empty).
REQ-029 Reset mid-operation SHALL discard all in-flight results; no stale result appears after release.
REQ-030 The first input accepted after Rst rises SHALL emerge 2 cycles later.

Verification (DATAWIDTH=16)
REQ-031 Basic: SIGNED=0, a=3, b=4, c=5, out_ready=1 -> 2 cycles later z=8, x=8, gt=0.
REQ-032 Negative difference: a=10, b=20, c=2 -> z=30 (0x001E), x=0xFFF6, gt=1.
REQ-033 Wrap: a=0xFFFF, b=1, c=0xFFFF -> d=0, e=0xFFFE, x=0x0001, gt=0, z=0xFFFE.
REQ-034 Mode: a=0, b=0xFFFF, c=1 -> x=0x0001 in both modes.
- SIGNED=0: gt=1, z=0xFFFF.
- SIGNED=1: gt=0, z=0x0001.
REQ-035 Backpressure:
- Stimulus: 3 back-to-back inputs; out_ready=0 for 5 cycles, then 1.
- in_ready=0 while full; z/x stable while stalled.
- All 3 results delivered in order, each exactly once.
REQ-036 Reset mid-stream: Rst=0 with 2 results in flight -> out_valid=0 immediately.
- No stale output after release.
- Next input emerges after exactly 2 cycles.
